// File: rtl/bus_transfer_sequencer_pkg.sv
// Shared definitions for the bus transfer sequencer: register codes,
// control-word bit positions, FSM states and the queued command format.
package bus_seq_pkg;

    // Register codes as carried in a command's src/dst fields
    localparam logic [2:0] REG_A   = 3'd0;
    localparam logic [2:0] REG_B   = 3'd1;
    localparam logic [2:0] REG_C   = 3'd2;
    localparam logic [2:0] REG_P   = 3'd3;
    localparam logic [2:0] REG_S   = 3'd4;
    localparam logic [2:0] REG_ST  = 3'd5;
    localparam logic [2:0] SRC_EXT = 3'd6;

    // Control word layout: one-hot loads in the low half, one-hot OEs above
    localparam int NUM_REGS  = 6;
    localparam int LOAD_BASE = 0;
    localparam int OE_BASE   = 6;
    localparam int CTRL_W    = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] src;
        logic [2:0] dst;
    } cmd_t;

    // A command is executable when its source is a register or the external
    // driver and its destination is a real register.
    function automatic logic cmd_is_valid(input logic [2:0] src, input logic [2:0] dst);
        return (src != 3'd7) && (dst <= REG_ST);
    endfunction

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// Command handshake and register-bus control signals of the sequencer.
// The master modport is the sequencer itself (it masters the register bus);
// the slave modport is the decoder / register-file side that talks to it.
interface bus_transfer_sequencer_if #(
    parameter int COUNT_W = 16
);
    logic               cmd_valid_in;
    logic               cmd_ready_out;
    logic [2:0]         cmd_src_in;
    logic [2:0]         cmd_dst_in;
    logic               stall_in;
    logic [11:0]        register_control_out;
    logic               ext_oe_out;
    logic               busy_out;
    logic               error_out;
    logic [COUNT_W-1:0] xfer_count_out;

    modport master (
        input  cmd_valid_in, cmd_src_in, cmd_dst_in, stall_in,
        output cmd_ready_out, register_control_out, ext_oe_out,
               busy_out, error_out, xfer_count_out
    );

    modport slave (
        output cmd_valid_in, cmd_src_in, cmd_dst_in, stall_in,
        input  cmd_ready_out, register_control_out, ext_oe_out,
               busy_out, error_out, xfer_count_out
    );
endinterface

// File: rtl/bus_transfer_sequencer_xfer_cmd_fifo.sv
// Small synchronous command queue with registered read data.
// pop_data updates on the edge that pops and holds until the next pop,
// so the consumer can keep using the popped command for several cycles.
module xfer_cmd_fifo
    import bus_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock_in,
    input  logic reset_n_in,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    cmd_t          pop_data_reg;
    logic [AW:0]   wr_ptr_reg;
    logic [AW:0]   rd_ptr_reg;
    logic          do_push;
    logic          do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = pop_data_reg;

    // Storage array write; no reset so it can map onto RAM
    always_ff @(posedge clock_in) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Registered read of the head entry when it is popped
    always_ff @(posedge clock_in) begin
        if (do_pop) begin
            pop_data_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    // Pointer update; reset empties the queue
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_transfer_sequencer.sv
// Register-bus master: turns queued src->dst moves into the one-hot register
// control word. Each transfer is DRIVE (OE only), LOAD (OE + load) and a GAP
// turnaround. Control outputs are registered from the current state, so they
// appear one cycle after the state is entered.
module bus_transfer_sequencer
    import bus_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int COUNT_W    = 16
) (
    input  logic clock_in,
    input  logic reset_n_in,
    bus_transfer_sequencer_if.master bus
);
    state_t             state_reg;
    state_t             state_next;
    cmd_t               push_cmd;
    cmd_t               head_cmd;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               push;
    logic               pop;
    logic               driving;
    logic               loading;
    logic [CTRL_W-1:0]  ctrl_reg;
    logic [CTRL_W-1:0]  ctrl_next;
    logic               ext_oe_reg;
    logic               ext_oe_next;
    logic               error_reg;
    logic [COUNT_W-1:0] count_reg;

    // Invalid commands are handshaken away but never reach the queue
    assign push_cmd = '{src: bus.cmd_src_in, dst: bus.cmd_dst_in};
    assign accept   = bus.cmd_valid_in && !fifo_full;
    assign push     = accept && cmd_is_valid(bus.cmd_src_in, bus.cmd_dst_in);

    xfer_cmd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock_in  (clock_in),
        .reset_n_in(reset_n_in),
        .push      (push),
        .push_data (push_cmd),
        .pop       (pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state logic; IDLE pops the queue head as it leaves
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE:   if (!bus.stall_in) state_next = LOAD;
            LOAD:    state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control word decode from the current state and popped command
    assign driving     = (state_reg == DRIVE) || (state_reg == LOAD);
    assign loading     = (state_reg == LOAD);
    assign ext_oe_next = driving && (head_cmd.src == SRC_EXT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign ctrl_next[OE_BASE + gi]   = driving && (head_cmd.src == 3'(gi));
            assign ctrl_next[LOAD_BASE + gi] = loading && (head_cmd.dst == 3'(gi));
        end
    endgenerate

    // State, registered outputs, sticky error and transfer counter
    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_reg  <= IDLE;
            ctrl_reg   <= '0;
            ext_oe_reg <= 1'b0;
            error_reg  <= 1'b0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            ctrl_reg   <= ctrl_next;
            ext_oe_reg <= ext_oe_next;
            if (accept && !cmd_is_valid(bus.cmd_src_in, bus.cmd_dst_in)) begin
                error_reg <= 1'b1;
            end
            if (state_reg == LOAD) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    assign bus.register_control_out = ctrl_reg;
    assign bus.ext_oe_out            = ext_oe_reg;
    assign bus.error_out             = error_reg;
    assign bus.xfer_count_out        = count_reg;
    assign bus.cmd_ready_out         = !fifo_full;
    assign bus.busy_out              = (state_reg != IDLE) || !fifo_empty;

    // Bus safety: one driver, one loader, never a load without a driver
    always_ff @(posedge clock_in) begin
        if (reset_n_in) begin
            assert ($countones({ctrl_reg[OE_BASE +: NUM_REGS], ext_oe_reg}) <= 1);
            assert ($countones(ctrl_reg[LOAD_BASE +: NUM_REGS]) <= 1);
            assert (!(|ctrl_reg[LOAD_BASE +: NUM_REGS]) ||
                    (|ctrl_reg[OE_BASE +: NUM_REGS]) || ext_oe_reg);
        end
    end
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer with a small register-file model
// that captures bus data on the falling edge, as the real register file does.
module tb_bus_transfer_sequencer;
    localparam logic [15:0] EXT_DATA = 16'hBEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] regs [6] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

    logic [11:0] oe_tab [4] = '{12'h040, 12'h100, 12'h200, 12'h400};
    logic [11:0] ld_tab [4] = '{12'h044, 12'h108, 12'h210, 12'h420};

    bus_transfer_sequencer_if #(.COUNT_W(16)) bus ();

    bus_transfer_sequencer #(
        .FIFO_DEPTH(4),
        .COUNT_W   (16)
    ) dut (
        .clock_in  (clk),
        .reset_n_in(rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Register-file model: the enabled driver's value is captured on negedge
    always @(negedge clk) begin
        logic [15:0] bus_val;
        bus_val = bus.ext_oe_out ? EXT_DATA : 16'h0000;
        for (int i = 0; i < 6; i++)
            if (bus.register_control_out[6+i] === 1'b1) bus_val = regs[i];
        for (int i = 0; i < 6; i++)
            if (bus.register_control_out[i] === 1'b1) regs[i] = bus_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_invariants();
        check("oe_onehot", 32'($countones({bus.register_control_out[11:6], bus.ext_oe_out}) <= 1), 1);
        check("load_onehot", 32'($countones(bus.register_control_out[5:0]) <= 1), 1);
        check("load_has_driver",
              32'(!(|bus.register_control_out[5:0]) || (|bus.register_control_out[11:6]) || bus.ext_oe_out), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_invariants();
    endtask

    task automatic send_cmd(input logic [2:0] src, input logic [2:0] dst);
        bus.cmd_valid_in = 1'b1;
        bus.cmd_src_in   = src;
        bus.cmd_dst_in   = dst;
        $display("cmd src=%0d dst=%0d at %0t", src, dst, $time);
    endtask

    task automatic no_cmd();
        bus.cmd_valid_in = 1'b0;
        bus.cmd_src_in   = 3'd0;
        bus.cmd_dst_in   = 3'd0;
    endtask

    initial begin
        no_cmd();
        bus.stall_in = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ctrl", 32'(bus.register_control_out), 0);
        check("rst_ext", 32'(bus.ext_oe_out), 0);
        check("rst_err", 32'(bus.error_out), 0);
        check("rst_count", 32'(bus.xfer_count_out), 0);
        check("rst_busy", 32'(bus.busy_out), 0);
        check("rst_ready", 32'(bus.cmd_ready_out), 1);
        rst_n = 1'b1;
        tick();

        // A -> B basic latency
        send_cmd(3'd0, 3'd1);
        tick();                                   // edge N
        no_cmd();
        check("t1_n0_ctrl", 32'(bus.register_control_out), 0);
        check("t1_busy", 32'(bus.busy_out), 1);
        tick();
        check("t1_n1_ctrl", 32'(bus.register_control_out), 0);
        tick();
        check("t1_drive", 32'(bus.register_control_out), 32'h040);
        tick();
        check("t1_load", 32'(bus.register_control_out), 32'h042);
        tick();
        check("t1_gap", 32'(bus.register_control_out), 0);
        check("t1_count", 32'(bus.xfer_count_out), 1);
        check("t1_regB", 32'(regs[1]), 32'h1111);
        check("t1_idle_busy", 32'(bus.busy_out), 0);

        // B -> A with 5-cycle stall; fill the queue meanwhile
        send_cmd(3'd1, 3'd0);
        tick();                                   // edge N
        bus.stall_in = 1'b1;
        send_cmd(3'd0, 3'd2);
        tick();                                   // N+1
        check("st_n1", 32'(bus.register_control_out), 0);
        send_cmd(3'd2, 3'd3);
        tick();                                   // N+2
        check("st_oe2", 32'(bus.register_control_out), 32'h080);
        send_cmd(3'd3, 3'd4);
        tick();                                   // N+3
        check("st_oe3", 32'(bus.register_control_out), 32'h080);
        send_cmd(3'd4, 3'd5);
        tick();                                   // N+4
        check("st_oe4", 32'(bus.register_control_out), 32'h080);
        check("full_ready", 32'(bus.cmd_ready_out), 0);
        send_cmd(3'd2, 3'd2);                     // must be refused while full
        tick();                                   // N+5
        no_cmd();
        check("st_oe5", 32'(bus.register_control_out), 32'h080);
        check("full_ready2", 32'(bus.cmd_ready_out), 0);
        tick();                                   // N+6
        bus.stall_in = 1'b0;
        check("st_oe6", 32'(bus.register_control_out), 32'h080);
        tick();                                   // N+7
        check("st_oe7", 32'(bus.register_control_out), 32'h080);
        tick();                                   // N+8
        check("st_load", 32'(bus.register_control_out), 32'h081);
        tick();                                   // N+9
        check("st_gap", 32'(bus.register_control_out), 0);
        check("st_count", 32'(bus.xfer_count_out), 2);
        check("st_busy", 32'(bus.busy_out), 1);
        tick();                                   // N+10
        check("q_n10", 32'(bus.register_control_out), 0);

        // Queued chain A->C, C->P, P->S, S->ST at 4-cycle spacing
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("q%0d_drive", k), 32'(bus.register_control_out), 32'(oe_tab[k]));
            tick();
            check($sformatf("q%0d_load", k), 32'(bus.register_control_out), 32'(ld_tab[k]));
            tick();
            check($sformatf("q%0d_gap", k), 32'(bus.register_control_out), 0);
            tick();
            check($sformatf("q%0d_idle", k), 32'(bus.register_control_out), 0);
        end
        check("q_count", 32'(bus.xfer_count_out), 6);
        check("q_busy", 32'(bus.busy_out), 0);
        check("q_regST", 32'(regs[5]), 32'h1111);

        // External source -> P
        send_cmd(3'd6, 3'd3);
        tick();
        no_cmd();
        tick();
        check("ext_n1_ext", 32'(bus.ext_oe_out), 0);
        tick();
        check("ext_drive_ext", 32'(bus.ext_oe_out), 1);
        check("ext_drive_ctrl", 32'(bus.register_control_out), 0);
        tick();
        check("ext_load_ext", 32'(bus.ext_oe_out), 1);
        check("ext_load_ctrl", 32'(bus.register_control_out), 32'h008);
        tick();
        check("ext_gap_ext", 32'(bus.ext_oe_out), 0);
        check("ext_gap_ctrl", 32'(bus.register_control_out), 0);
        check("ext_regP", 32'(regs[3]), 32'(EXT_DATA));
        check("ext_count", 32'(bus.xfer_count_out), 7);
        check("pre_err", 32'(bus.error_out), 0);

        // Invalid destination
        send_cmd(3'd0, 3'd7);
        tick();
        no_cmd();
        check("bad_dst_err", 32'(bus.error_out), 1);
        check("bad_dst_busy", 32'(bus.busy_out), 0);
        check("bad_dst_ready", 32'(bus.cmd_ready_out), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bad_dst_quiet", 32'({bus.ext_oe_out, bus.register_control_out}), 0);
        end
        check("bad_dst_count", 32'(bus.xfer_count_out), 7);

        // Invalid source
        send_cmd(3'd7, 3'd0);
        tick();
        no_cmd();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bad_src_quiet", 32'({bus.ext_oe_out, bus.register_control_out}), 0);
        end
        check("bad_src_count", 32'(bus.xfer_count_out), 7);
        check("err_sticky", 32'(bus.error_out), 1);

        // Reset during LOAD with two commands still queued
        send_cmd(3'd0, 3'd1);
        tick();                                   // N
        send_cmd(3'd2, 3'd3);
        tick();                                   // N+1
        send_cmd(3'd3, 3'd4);
        tick();                                   // N+2
        no_cmd();
        check("rl_drive", 32'(bus.register_control_out), 32'h040);
        tick();                                   // N+3
        check("rl_load", 32'(bus.register_control_out), 32'h042);
        rst_n = 1'b0;
        tick();
        check("rl_ctrl", 32'(bus.register_control_out), 0);
        check("rl_ext", 32'(bus.ext_oe_out), 0);
        check("rl_err", 32'(bus.error_out), 0);
        check("rl_count", 32'(bus.xfer_count_out), 0);
        check("rl_busy", 32'(bus.busy_out), 0);
        check("rl_ready", 32'(bus.cmd_ready_out), 1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rl_after_ctrl", 32'(bus.register_control_out), 0);
            check("rl_after_busy", 32'(bus.busy_out), 0);
        end
        check("rl_after_count", 32'(bus.xfer_count_out), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
